// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : game_pkg
//  Description : Shared play-field geometry and the alien bomb state
//                encoding. Used by the bomb, player bullet and VGA
//                formatter blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

  // Play-field grid geometry
  localparam int X_W = 5;                 // column index width
  localparam int Y_W = 4;                 // row index width
  localparam logic [Y_W-1:0] Y_MAX = 4'd15;  // bottom row of the screen

  // Bomb controller states
  typedef enum logic [1:0] {
    BOMB_IDLE = 2'd0,
    BOMB_FALL = 2'd1,
    BOMB_BOOM = 2'd2
  } bomb_state_e;

  // Larger of two integers, for sizing counters shared by two periods
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage : game_pkg
`default_nettype wire

// File: rtl/bomb_step_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bomb_step_timer
//  Description : Enable-gated modulo counter. Counts 0..last_i and wraps,
//                with a terminal-count strobe while the count equals last_i.
//                load_zero_i (when enabled) and clr_i (always) force 0.
//  Ports       : clk         - system clock
//                reset       - asynchronous active-low reset
//                clr_i       - synchronous clear, ignores enable
//                en_i        - count enable; 0 holds the count
//                load_zero_i - restart the count at 0 on the next enabled edge
//                last_i      - terminal value (period - 1)
//                tc_o        - high while the count sits at last_i
//  Revision    : 1.0 - initial release
// ============================================================================
module bomb_step_timer #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             load_zero_i,
  input  logic [WIDTH-1:0] last_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign tc_o = (count_q == last_i);

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      if (load_zero_i || tc_o) begin
        count_d = '0;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : bomb_step_timer
`default_nettype wire

// File: rtl/alien_bomb.sv
`default_nettype none
// ============================================================================
//  Module      : alien_bomb
//  Description : Single alien bomb. Released from an alien cell, falls one
//                row every FALL_PERIOD enabled cycles, and ends by being
//                intercepted by the player bullet, hitting the ship (then
//                exploding for BOOM_CYCLES) or leaving the bottom row.
//  Ports       : clk, reset (async, active-low), clr (sync clear), enable
//                drop/dropX/dropY        - release request and alien cell
//                shipX                   - ship column (ship row = SHIP_ROW)
//                bulletFlying/X/Y        - player bullet
//                falling/exploding       - bomb status
//                bombX/bombY             - bomb cell
//                shipHit/intercepted     - one-cycle event pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module alien_bomb
  import game_pkg::*;
#(
  parameter int FALL_PERIOD = 12000000,
  parameter int BOOM_CYCLES = 6000000,
  parameter int SHIP_ROW    = 14
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clr,
  input  logic           enable,
  input  logic           drop,
  input  logic [X_W-1:0] dropX,
  input  logic [Y_W-1:0] dropY,
  input  logic [X_W-1:0] shipX,
  input  logic           bulletFlying,
  input  logic [X_W-1:0] bulletX,
  input  logic [Y_W-1:0] bulletY,
  output logic           falling,
  output logic           exploding,
  output logic [X_W-1:0] bombX,
  output logic [Y_W-1:0] bombY,
  output logic           shipHit,
  output logic           intercepted
);

  // One counter serves both the fall step and the explosion hold
  localparam int CNT_MAX = max_int(FALL_PERIOD, BOOM_CYCLES);
  localparam int CW      = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);

  localparam logic [CW-1:0]  FALL_LAST  = CW'(FALL_PERIOD - 1);
  localparam logic [CW-1:0]  BOOM_LAST  = CW'(BOOM_CYCLES - 1);
  localparam logic [Y_W-1:0] SHIP_ROW_Y = Y_W'(SHIP_ROW);

  bomb_state_e    state_q;
  logic           falling_q;
  logic           exploding_q;
  logic [X_W-1:0] bombx_q;
  logic [Y_W-1:0] bomby_q;
  logic           shiphit_q;
  logic           intercepted_q;

  logic           intercept_d;
  logic           hit_d;
  logic           timer_zero_d;
  logic [CW-1:0]  timer_last_d;
  logic           timer_tc;

  // Collision checks use the registered bomb position; the bullet wins
  // over the ship when both line up on the same edge.
  always_comb begin
    intercept_d  = (state_q == BOMB_FALL) && bulletFlying &&
                   (bulletX == bombx_q) && (bulletY == bomby_q);
    hit_d        = (state_q == BOMB_FALL) && !intercept_d &&
                   (bomby_q == SHIP_ROW_Y) && (bombx_q == shipX);
    // Counter parks at 0 while idle so a fresh drop starts a full period,
    // and restarts when the bomb leaves FALL by collision.
    timer_zero_d = (state_q == BOMB_IDLE) || intercept_d || hit_d;
    timer_last_d = (state_q == BOMB_BOOM) ? BOOM_LAST : FALL_LAST;
  end

  bomb_step_timer #(
    .WIDTH (CW)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .clr_i       (clr),
    .en_i        (enable),
    .load_zero_i (timer_zero_d),
    .last_i      (timer_last_d),
    .tc_o        (timer_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= BOMB_IDLE;
      falling_q     <= 1'b0;
      exploding_q   <= 1'b0;
      bombx_q       <= '0;
      bomby_q       <= '0;
      shiphit_q     <= 1'b0;
      intercepted_q <= 1'b0;
    end else if (clr) begin
      state_q       <= BOMB_IDLE;
      falling_q     <= 1'b0;
      exploding_q   <= 1'b0;
      bombx_q       <= '0;
      bomby_q       <= '0;
      shiphit_q     <= 1'b0;
      intercepted_q <= 1'b0;
    end else begin
      // Event pulses last one cycle and are never raised while frozen
      shiphit_q     <= 1'b0;
      intercepted_q <= 1'b0;
      if (enable) begin
        case (state_q)
          BOMB_IDLE: begin
            // An alien on the bottom row has nowhere to drop into
            if (drop && (dropY != Y_MAX)) begin
              bombx_q   <= dropX;
              bomby_q   <= dropY + Y_W'(1);
              falling_q <= 1'b1;
              state_q   <= BOMB_FALL;
            end
          end
          BOMB_FALL: begin
            if (intercept_d) begin
              intercepted_q <= 1'b1;
              falling_q     <= 1'b0;
              bombx_q       <= '0;
              bomby_q       <= '0;
              state_q       <= BOMB_IDLE;
            end else if (hit_d) begin
              shiphit_q   <= 1'b1;
              falling_q   <= 1'b0;
              exploding_q <= 1'b1;
              state_q     <= BOMB_BOOM;
            end else if (timer_tc) begin
              if (bomby_q == Y_MAX) begin
                // Fell off the bottom without touching anything
                falling_q <= 1'b0;
                bombx_q   <= '0;
                bomby_q   <= '0;
                state_q   <= BOMB_IDLE;
              end else begin
                bomby_q <= bomby_q + Y_W'(1);
              end
            end
          end
          BOMB_BOOM: begin
            if (timer_tc) begin
              exploding_q <= 1'b0;
              bombx_q     <= '0;
              bomby_q     <= '0;
              state_q     <= BOMB_IDLE;
            end
          end
          default: begin
            state_q <= BOMB_IDLE;
          end
        endcase
      end
    end
  end

  assign falling     = falling_q;
  assign exploding   = exploding_q;
  assign bombX       = bombx_q;
  assign bombY       = bomby_q;
  assign shipHit     = shiphit_q;
  assign intercepted = intercepted_q;

endmodule : alien_bomb
`default_nettype wire

// File: doc/alien_bomb.md
Name: alien_bomb

Overview:
- Enemy-side counterpart of the player bullet: a single alien bomb that drops from an alien's grid cell downward toward the ship row.
- Reports ship hits, interception by the player bullet, and misses at the screen bottom.
- Sits beside the bullet block and feeds the VGA formatter (bombX/bombY/falling/exploding) and the game controller (shipHit/intercepted).
- One bomb in flight at a time.

Parameters:
- FALL_PERIOD, 12000000, enabled clock cycles per one-row fall step (default is 1 row/s at 12 MHz); minimum 2.
- BOOM_CYCLES, 6000000, enabled cycles the explosion is held after a ship hit; minimum 1.
- SHIP_ROW, 14, grid row occupied by the ship; must be < 15.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- clr  in  1  synchronous clear, active-high; same effect as reset at the next edge
- enable  in  1  game running; 0 freezes all state
- drop  in  1  request to release a bomb (level sampled each edge)
- dropX  in  5  column of the dropping alien
- dropY  in  4  row of the dropping alien
- shipX  in  5  current ship column
- bulletFlying  in  1  player bullet active
- bulletX  in  5  player bullet column
- bulletY  in  4  player bullet row
- falling  out  1  bomb in flight
- exploding  out  1  explosion being displayed
- bombX  out  5  bomb column
- bombY  out  4  bomb row
- shipHit  out  1  one-cycle pulse, bomb struck the ship
- intercepted  out  1  one-cycle pulse, bomb destroyed by the bullet

Behaviour:
- All outputs are registered.
- Reset (async, reset=0) and clr (sync): state IDLE, step/boom counter 0. All outputs 0.
- clr has priority over everything except reset.
- enable=0: state, counters and positions hold. drop is ignored. No collision checks. shipHit and intercepted are 0.
- States: IDLE, FALL, BOOM.
- IDLE:
  - On an edge with enable & drop & dropY != 15: bombX <= dropX, bombY <= dropY+1, counter <= 0, falling <= 1, state FALL.
  - drop with dropY == 15 is ignored.
  - Latency from drop sampled to falling=1 is one edge.
- FALL, evaluated each enabled edge, in priority order:
  1. Intercept: bulletFlying & bulletX==bombX & bulletY==bombY. Then intercepted <= 1 for one cycle, falling <= 0, bombX/bombY <= 0, state IDLE.
  2. Ship hit: bombY==SHIP_ROW & bombX==shipX. Then shipHit <= 1 for one cycle, falling <= 0, exploding <= 1, bombX/bombY held, counter <= 0, state BOOM.
  3. Step: counter==FALL_PERIOD-1. Counter <= 0.
     - If bombY==15 (missed, bottom reached): falling <= 0, bombX/bombY <= 0, state IDLE. No pulse.
     - Else bombY <= bombY+1. No 4-bit wrap is ever produced.
  4. Otherwise: counter+1.
- Intercept beats ship hit when both match on the same edge.
- drop during FALL or BOOM is ignored. It is not queued.
- BOOM:
  - counter increments on each enabled edge.
  - At counter==BOOM_CYCLES-1: exploding <= 0, bombX/bombY <= 0, counter <= 0, state IDLE.
  - drop may be accepted on the edge after returning to IDLE.
- Counter width is $clog2(max(FALL_PERIOD, BOOM_CYCLES)). A single counter is shared by FALL and BOOM.
- reset asserted in any state takes effect immediately, without waiting for clk.

Decomposition:
- Shared package game_pkg:
  - grid widths X_W=5, Y_W=4
  - Y_MAX=15
  - bomb state encoding (IDLE=0, FALL=1, BOOM=2)
  - Reused by the bullet and formatter blocks.
- One sub-module bomb_step_timer:
  - Enable-gated modulo counter with load-zero input.
  - Outputs a terminal-count strobe, parameterised by its period.
  - Instantiated once, with its period muxed between FALL_PERIOD and BOOM_CYCLES by state.

Test Plan (FALL_PERIOD=4, BOOM_CYCLES=3, SHIP_ROW=14):
- Reset, then drop=1 for one cycle with dropX=7, dropY=2 -> next edge falling=1, bombX=7, bombY=3. After 4 more enabled edges, bombY=4.
- Miss: shipX=0, bomb at column 7 reaches bombY=15. After the next 4 edges: falling=0, bombX=bombY=0, shipHit never 1.
- Ship hit: shipX=7. On the edge after bombY becomes 14: shipHit=1 for exactly one cycle, exploding=1 for 3 cycles with bomb at (7,14). Then IDLE with all outputs 0.
- Intercept: bulletFlying=1, bullet at (7,5) while the bomb is at (7,5) -> intercepted=1 for one cycle, falling=0. Repeat with the bomb at (7,14), shipX=7 and the bullet also at (7,14) -> intercepted=1, shipHit stays 0.
- Robustness:
  - drop pulsed at dropX=20 while FALL -> bombX stays 7.
  - enable=0 for 10 cycles mid-FALL -> bombY and step timing frozen; resumes with the same remaining count.
  - dropY=15 in IDLE -> stays IDLE.
- Reset/clear: reset=0 mid-FALL (between clock edges) -> falling, bombX, bombY are 0 before the next edge. clr=1 during BOOM -> next edge exploding=0, state IDLE.
